// File: rtl/regfile_2r1w.sv
// Purpose: NREGS x DATA_W register file, one write port, two independent combinational read ports, per-register written-since-reset valid bits.
// Latency: reads are zero-cycle; writes are visible from the clock edge onward (same cycle with REGFILE_WRITE_BYPASS_EN defined).
// Backpressure: none; a write is accepted every cycle that write=1. Optional macro: REGFILE_WRITE_BYPASS_EN (write-to-read forwarding).
module regfile_2r1w #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [ADDR_W-1:0]       writenum,
    input  logic                    write,
    input  logic [ADDR_W-1:0]       readnum_a,
    input  logic [ADDR_W-1:0]       readnum_b,
    output logic [DATA_W-1:0]       data_out_a,
    output logic [DATA_W-1:0]       data_out_b,
    output logic                    valid_a,
    output logic                    valid_b,
    output logic [(2**ADDR_W)-1:0]  load
);

    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_vld;
    logic [NREGS-1:0]  w_load;
    logic [DATA_W-1:0] w_dat_a;
    logic [DATA_W-1:0] w_dat_b;
    logic              w_vld_a;
    logic              w_vld_b;

    // One-hot load decode; gated by write so an unknown writenum cannot leak through while idle.
    always_comb begin
        w_load = '0;
        if (write) begin
            w_load[writenum] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_load[0] = 1'b0;
        end
    end

    // Register array and valid bits; reset clears everything and overrides any concurrent write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_vld <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_load[i]) begin
                    r_regs[i] <= data_in;
                    r_vld[i]  <= 1'b1;
                end
            end
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic w_byp_a;
    logic w_byp_b;
    logic w_wr_live;

    // Forwarding qualifier: a live write to a real register (never the hardwired zero register).
    always_comb begin
        w_wr_live = write && !reset && !((ZERO_REG != 0) && (writenum == '0));
        w_byp_a   = w_wr_live && (readnum_a == writenum);
        w_byp_b   = w_wr_live && (readnum_b == writenum);
    end
`endif

    // Read port A: stored contents, zero register override, optional forwarding of the in-flight write.
    always_comb begin
        w_dat_a = r_regs[readnum_a];
        w_vld_a = r_vld[readnum_a];
        if ((ZERO_REG != 0) && (readnum_a == '0)) begin
            w_dat_a = '0;
            w_vld_a = 1'b1;
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (w_byp_a) begin
            w_dat_a = data_in;
            w_vld_a = 1'b1;
        end
`endif
    end

    // Read port B: identical to port A, fully independent index.
    always_comb begin
        w_dat_b = r_regs[readnum_b];
        w_vld_b = r_vld[readnum_b];
        if ((ZERO_REG != 0) && (readnum_b == '0)) begin
            w_dat_b = '0;
            w_vld_b = 1'b1;
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (w_byp_b) begin
            w_dat_b = data_in;
            w_vld_b = 1'b1;
        end
`endif
    end

    assign load       = w_load;
    assign data_out_a = w_dat_a;
    assign data_out_b = w_dat_b;
    assign valid_a    = w_vld_a;
    assign valid_b    = w_vld_b;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: table-driven vectors through an expectation queue, plus hand sequences for
// mid-cycle reset and the hardwired zero register (second instance with ZERO_REG=1).
module tb_regfile_2r1w;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;
    logic [15:0] data_out_a, data_out_b, zdata_out_a, zdata_out_b;
    logic        valid_a, valid_b, zvalid_a, zvalid_b;
    logic [7:0]  load, zload;

    regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
        .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(data_out_a), .data_out_b(data_out_b),
        .valid_a(valid_a), .valid_b(valid_b), .load(load)
    );

    regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
        .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(zdata_out_a), .data_out_b(zdata_out_b),
        .valid_a(zvalid_a), .valid_b(zvalid_b), .load(zload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  wn;
        logic [15:0] din;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        eva;
        logic        evb;
        logic [7:0]  eload;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        va;
        logic        vb;
        logic [7:0]  ld;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one vector after the rising edge, queue its expectation, compare at the falling edge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t g;
        @(posedge clk);
        #1;
        write     = v.wr;
        writenum  = v.wn;
        data_in   = v.din;
        readnum_a = v.ra;
        readnum_b = v.rb;
        e.a  = v.ea;
        e.b  = v.eb;
        e.va = v.eva;
        e.vb = v.evb;
        e.ld = v.eload;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (v.wr && v.ra == v.wn) begin e.a = v.din; e.va = 1'b1; end
        if (v.wr && v.rb == v.wn) begin e.b = v.din; e.vb = 1'b1; end
`endif
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk($sformatf("vec%0d_queue_empty", idx), 32'(0), 32'(1));
        end else begin
            g = exp_q.pop_front();
            chk($sformatf("vec%0d_data_a", idx), 32'(data_out_a), 32'(g.a));
            chk($sformatf("vec%0d_data_b", idx), 32'(data_out_b), 32'(g.b));
            chk($sformatf("vec%0d_valid_a", idx), 32'(valid_a), 32'(g.va));
            chk($sformatf("vec%0d_valid_b", idx), 32'(valid_b), 32'(g.vb));
            chk($sformatf("vec%0d_load", idx), 32'(load), 32'(g.ld));
        end
    endtask

    initial begin
        //          wr  wn     din       ra    rb    ea        eb        va    vb    load
        vecs[0]  = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 3'd1, 16'h0002, 3'd1, 3'd1, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h02};
        vecs[2]  = '{1'b0, 3'd1, 16'h0003, 3'd1, 3'd0, 16'h0002, 16'h0000, 1'b1, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 3'd1, 16'h0003, 3'd1, 3'd0, 16'h0002, 16'h0000, 1'b1, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 3'd1, 16'h0003, 3'd1, 3'd0, 16'h0002, 16'h0000, 1'b1, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 3'd1, 16'h0003, 3'd1, 3'd2, 16'h0002, 16'h0000, 1'b1, 1'b0, 8'h02};
        vecs[6]  = '{1'b1, 3'd3, 16'hBEEF, 3'd1, 3'd3, 16'h0003, 16'h0000, 1'b1, 1'b0, 8'h08};
        vecs[7]  = '{1'b1, 3'd5, 16'h1234, 3'd3, 3'd5, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 8'h20};
        vecs[8]  = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 16'hBEEF, 16'h1234, 1'b1, 1'b1, 8'h00};
        vecs[9]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd3, 16'h1234, 16'hBEEF, 1'b1, 1'b1, 8'h00};
        vecs[10] = '{1'b1, 3'd3, 16'h0101, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF, 1'b1, 1'b1, 8'h08};
        vecs[11] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 16'h0101, 16'h0000, 1'b1, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd6, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h80};
        vecs[13] = '{1'b0, 3'bxxx, 16'h0000, 3'd7, 3'd6, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 8'h00};

        reset = 1'b1; write = 1'b0; writenum = '0; data_in = '0; readnum_a = '0; readnum_b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state on every index through both ports, sweeping in opposite directions.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            readnum_a = 3'(i);
            readnum_b = 3'(7 - i);
            @(negedge clk);
            chk($sformatf("rst_data_a%0d", i), 32'(data_out_a), 32'h0);
            chk($sformatf("rst_data_b%0d", i), 32'(data_out_b), 32'h0);
            chk($sformatf("rst_valid_a%0d", i), 32'(valid_a), 32'h0);
            chk($sformatf("rst_valid_b%0d", i), 32'(valid_b), 32'h0);
            chk($sformatf("rst_load%0d", i), 32'(load), 32'h0);
        end

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i], i);
        end

        // Mid-cycle reset: R6 = AAAA committed, then reset rises with a competing write pending.
        apply('{1'b1, 3'd6, 16'hAAAA, 3'd6, 3'd6, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h40}, 14);
        @(posedge clk);
        #1;
        write = 1'b1; writenum = 3'd6; data_in = 16'h5555; readnum_a = 3'd6; readnum_b = 3'd3;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("pre_rst_r6", 32'(data_out_a), 32'h5555);
`else
        chk("pre_rst_r6", 32'(data_out_a), 32'hAAAA);
`endif
        chk("pre_rst_r3", 32'(data_out_b), 32'h0101);
        reset = 1'b1;
        #1;
        chk("async_rst_data_a", 32'(data_out_a), 32'h0);
        chk("async_rst_valid_a", 32'(valid_a), 32'h0);
        chk("async_rst_data_b", 32'(data_out_b), 32'h0);
        chk("async_rst_valid_b", 32'(valid_b), 32'h0);
        chk("async_rst_load", 32'(load), 32'h40);
        readnum_b = 3'd0;
        #1;
        chk("rst_zreg_valid_b", 32'(zvalid_b), 32'h1);
        chk("rst_noz_valid_b", 32'(valid_b), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_over_write_r6", 32'(data_out_a), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        write = 1'b0;
        #1;
        chk("post_rst_r6_data", 32'(data_out_a), 32'h0);
        chk("post_rst_r6_valid", 32'(valid_a), 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_r6_hold", 32'(data_out_a), 32'h0);

        // Hardwired zero register: write to index 0 is suppressed, reads give 0 with valid 1.
        write = 1'b1; writenum = 3'd0; data_in = 16'hFFFF; readnum_a = 3'd0; readnum_b = 3'd0;
        #1;
        chk("zreg_load", 32'(zload), 32'h00);
        chk("zreg_data_a_pre", 32'(zdata_out_a), 32'h0);
        chk("zreg_valid_a_pre", 32'(zvalid_a), 32'h1);
        chk("noz_load0", 32'(load), 32'h01);
        @(posedge clk);
        #1;
        write = 1'b0;
        #1;
        chk("zreg_data_a_post", 32'(zdata_out_a), 32'h0);
        chk("zreg_valid_a_post", 32'(zvalid_a), 32'h1);
        chk("noz_r0_written", 32'(data_out_a), 32'hFFFF);
        chk("noz_r0_valid", 32'(valid_a), 32'h1);

        if (exp_q.size() != 0) begin
            chk("queue_drained", 32'(exp_q.size()), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
